// File: rtl/axi_read_burst_splitter_mid.sv
// axi_read_burst_splitter_mid
// Read-command front end: splits one linear read command into AXI4 INCR
// bursts that respect the 4KB boundary and MAX_BURST, caps the number of
// in-flight bursts, and passes R data through with a command-level last flag.
module axi_read_burst_splitter_mid #(
    parameter int unsigned ADDR_W          = 64,
    parameter int unsigned DATA_W          = 512,
    parameter int unsigned ID_W            = 1,
    parameter int unsigned MAX_BURST       = 64,
    parameter int unsigned MAX_OUTSTANDING = 8
) (
    input  logic              ap_clk,
    input  logic              areset,
    // command side
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [31:0]       cmd_beats,
    // AXI AR channel
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [7:0]        m_axi_arlen,
    output logic [2:0]        m_axi_arsize,
    output logic [1:0]        m_axi_arburst,
    output logic [3:0]        m_axi_arcache,
    output logic [2:0]        m_axi_arprot,
    output logic [3:0]        m_axi_arqos,
    output logic [3:0]        m_axi_arregion,
    output logic              m_axi_arlock,
    output logic [ID_W-1:0]   m_axi_arid,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    // AXI R channel
    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rlast,
    input  logic [ID_W-1:0]   m_axi_rid,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready,
    // downstream data stream
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              data_last,
    output logic              busy,
    output logic              err
);

    localparam int unsigned BPB   = DATA_W / 8;
    localparam int unsigned SIZE  = $clog2(BPB);
    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN
    } state_t;

    state_t             r_state;
    logic               r_cmd_ready;
    logic               r_arvalid;
    logic [ADDR_W-1:0]  r_araddr;
    logic [7:0]         r_arlen;
    logic [ADDR_W-1:0]  r_addr;
    logic [31:0]        r_remaining;
    logic [31:0]        r_len;
    logic [31:0]        r_beats;
    logic [31:0]        r_beat_cnt;
    logic [OUT_W-1:0]   r_out_cnt;
    logic               r_err;

    logic [31:0]        w_page_off;
    logic [31:0]        w_page_room;
    logic [31:0]        w_len;
    logic               w_cmd_hs;
    logic               w_ar_hs;
    logic               w_r_hs;
    logic               w_r_last_hs;
    logic               w_unused_ok;

    assign w_cmd_hs    = cmd_valid & r_cmd_ready;
    assign w_ar_hs     = r_arvalid & m_axi_arready;
    assign w_r_hs      = m_axi_rvalid & data_ready;
    assign w_r_last_hs = w_r_hs & m_axi_rlast;

    // Beats left before the next 4KB page; the address is beat-aligned so this is exact.
    assign w_page_off  = {20'd0, r_addr[11:0]};
    assign w_page_room = (32'd4096 - w_page_off) >> SIZE;

    // Next burst length: min(remaining, MAX_BURST, beats to page end)
    always_comb begin
        w_len = r_remaining;
        if (w_len > 32'(MAX_BURST)) begin
            w_len = 32'(MAX_BURST);
        end
        if (w_len > w_page_room) begin
            w_len = w_page_room;
        end
    end

    // Command FSM: latch command, present one registered AR at a time, drain
    always_ff @(posedge ap_clk) begin
        if (areset) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b0;
            r_arvalid   <= 1'b0;
            r_araddr    <= '0;
            r_arlen     <= '0;
            r_addr      <= '0;
            r_remaining <= '0;
            r_len       <= '0;
            r_beats     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (w_cmd_hs) begin
                        r_addr      <= {cmd_addr[ADDR_W-1:SIZE], {SIZE{1'b0}}};
                        r_remaining <= cmd_beats;
                        r_beats     <= cmd_beats;
                        if (cmd_beats != 32'd0) begin
                            r_state     <= S_ISSUE;
                            r_cmd_ready <= 1'b0;
                        end
                    end
                end
                S_ISSUE: begin
                    // arvalid drops for one cycle after each handshake, so the
                    // outstanding count seen here already includes the last burst.
                    if (r_arvalid) begin
                        if (m_axi_arready) begin
                            r_arvalid   <= 1'b0;
                            r_addr      <= r_addr + (ADDR_W'(r_len) << SIZE);
                            r_remaining <= r_remaining - r_len;
                            if (r_remaining == r_len) begin
                                r_state <= S_DRAIN;
                            end
                        end
                    end else if (r_out_cnt < OUT_W'(MAX_OUTSTANDING)) begin
                        r_arvalid <= 1'b1;
                        r_araddr  <= r_addr;
                        r_arlen   <= 8'(w_len - 32'd1);
                        r_len     <= w_len;
                    end
                end
                S_DRAIN: begin
                    if (r_out_cnt == '0) begin
                        r_state     <= S_IDLE;
                        r_cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Outstanding burst counter: +1 per AR handshake, -1 per rlast handshake
    always_ff @(posedge ap_clk) begin
        if (areset) begin
            r_out_cnt <= '0;
        end else begin
            case ({w_ar_hs, w_r_last_hs})
                2'b10:   r_out_cnt <= r_out_cnt + 1'b1;
                2'b01:   if (r_out_cnt != '0) r_out_cnt <= r_out_cnt - 1'b1;
                default: r_out_cnt <= r_out_cnt;
            endcase
        end
    end

    // Per-command beat counter and sticky error flag, both cleared on accept
    always_ff @(posedge ap_clk) begin
        if (areset) begin
            r_beat_cnt <= '0;
            r_err      <= 1'b0;
        end else if (w_cmd_hs) begin
            r_beat_cnt <= '0;
            r_err      <= 1'b0;
        end else if (w_r_hs) begin
            r_beat_cnt <= r_beat_cnt + 32'd1;
            if (m_axi_rresp != 2'b00) begin
                r_err <= 1'b1;
            end
        end
    end

    assign cmd_ready      = r_cmd_ready;
    assign busy           = (r_state != S_IDLE);
    assign err            = r_err;

    assign m_axi_araddr   = r_araddr;
    assign m_axi_arlen    = r_arlen;
    assign m_axi_arvalid  = r_arvalid;
    assign m_axi_arsize   = 3'(SIZE);
    assign m_axi_arburst  = 2'b01;
    assign m_axi_arcache  = 4'b0011;
    assign m_axi_arprot   = '0;
    assign m_axi_arqos    = '0;
    assign m_axi_arregion = '0;
    assign m_axi_arlock   = 1'b0;
    assign m_axi_arid     = '0;

    assign data_out       = m_axi_rdata;
    assign data_valid     = m_axi_rvalid;
    assign m_axi_rready   = data_ready;
    assign data_last      = m_axi_rvalid & (r_beat_cnt == (r_beats - 32'd1));

    // R id is ignored and the sub-beat address bits are discarded.
    assign w_unused_ok    = ^{m_axi_rid, cmd_addr[SIZE-1:0]};

endmodule

// File: tb/tb_axi_read_burst_splitter_mid.sv
// Directed testbench for axi_read_burst_splitter_mid: table of commands with
// hand-computed AR sequences, plus hand-written multi-cycle sequences.
module tb_axi_read_burst_splitter_mid;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 512;
    localparam int ID_W   = 1;
    localparam int MAXO   = 8;

    logic              ap_clk;
    logic              areset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [31:0]       cmd_beats;
    logic [ADDR_W-1:0] m_axi_araddr;
    logic [7:0]        m_axi_arlen;
    logic [2:0]        m_axi_arsize;
    logic [1:0]        m_axi_arburst;
    logic [3:0]        m_axi_arcache;
    logic [2:0]        m_axi_arprot;
    logic [3:0]        m_axi_arqos;
    logic [3:0]        m_axi_arregion;
    logic              m_axi_arlock;
    logic [ID_W-1:0]   m_axi_arid;
    logic              m_axi_arvalid;
    logic              m_axi_arready;
    logic [DATA_W-1:0] m_axi_rdata;
    logic [1:0]        m_axi_rresp;
    logic              m_axi_rlast;
    logic [ID_W-1:0]   m_axi_rid;
    logic              m_axi_rvalid;
    logic              m_axi_rready;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              data_ready;
    logic              data_last;
    logic              busy;
    logic              err;

    axi_read_burst_splitter_mid #(
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .ID_W           (ID_W),
        .MAX_BURST      (64),
        .MAX_OUTSTANDING(MAXO)
    ) dut (
        .ap_clk        (ap_clk),
        .areset        (areset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_addr      (cmd_addr),
        .cmd_beats     (cmd_beats),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arlen   (m_axi_arlen),
        .m_axi_arsize  (m_axi_arsize),
        .m_axi_arburst (m_axi_arburst),
        .m_axi_arcache (m_axi_arcache),
        .m_axi_arprot  (m_axi_arprot),
        .m_axi_arqos   (m_axi_arqos),
        .m_axi_arregion(m_axi_arregion),
        .m_axi_arlock  (m_axi_arlock),
        .m_axi_arid    (m_axi_arid),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rlast   (m_axi_rlast),
        .m_axi_rid     (m_axi_rid),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready),
        .data_out      (data_out),
        .data_valid    (data_valid),
        .data_ready    (data_ready),
        .data_last     (data_last),
        .busy          (busy),
        .err           (err)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [63:0]      addr;
        int               beats;
        int               n_ar;
        logic [2:0][63:0] ar_addr;
        logic [2:0][7:0]  ar_len;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    // bench-side AXI slave / consumer model state
    int          r_bursts_allowed;
    int          stall_cnt;
    int          err_idx;
    int          cmd_no;
    int          pend[$];
    int          bib;
    int          axi_ser;
    int          cons;
    int          n_last;
    int          cur_beats;
    int          model_out;
    int          cyc;
    bit          ar_slow;
    bit          acc;
    logic [63:0] ar_addr_q[$];
    logic [7:0]  ar_len_q[$];
    logic        prev_ar_stall;
    logic [63:0] prev_araddr;
    logic [7:0]  prev_arlen;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] pat(input int cmdn, input int s);
        logic [DATA_W-1:0] v;
        for (int i = 0; i < DATA_W / 32; i++) begin
            v[i*32 +: 32] = 32'((cmdn << 20) ^ s ^ (i << 12));
        end
        return v;
    endfunction

    function automatic vec_t mk(input logic [63:0] a, input int b, input int n,
                                input logic [63:0] a0, input logic [7:0] l0,
                                input logic [63:0] a1, input logic [7:0] l1,
                                input logic [63:0] a2, input logic [7:0] l2);
        vec_t v;
        v.addr = a;  v.beats = b;  v.n_ar = n;
        v.ar_addr[0] = a0; v.ar_addr[1] = a1; v.ar_addr[2] = a2;
        v.ar_len[0]  = l0; v.ar_len[1]  = l1; v.ar_len[2]  = l2;
        return v;
    endfunction

    // One clock: observe handshakes at negedge, then update driven inputs after posedge.
    task automatic step();
        logic       hs_ar, hs_r, hs_c, rl;
        logic [7:0] len_cap;
        @(negedge ap_clk);
        hs_ar   = m_axi_arvalid & m_axi_arready;
        hs_r    = m_axi_rvalid & m_axi_rready;
        rl      = m_axi_rlast;
        hs_c    = cmd_valid & cmd_ready;
        len_cap = m_axi_arlen;
        if (prev_ar_stall && !areset) begin
            chk("ar_hold_valid", m_axi_arvalid, 1);
            chk("ar_hold_addr", m_axi_araddr, prev_araddr);
            chk("ar_hold_len", m_axi_arlen, prev_arlen);
        end
        if (m_axi_arvalid === 1'b1) chk("ar_outstanding_cap", model_out < MAXO, 1);
        if (m_axi_rvalid) chk("r_only_when_busy", busy, 1);
        if (m_axi_rvalid && !data_ready) begin
            chk("rready_stall", m_axi_rready, 0);
            chk("valid_stall", data_valid, 1);
        end
        if (data_valid === 1'b1 && data_ready) begin
            chk("data_out", data_out == pat(cmd_no, cons), 1);
            chk("data_last", data_last, cons == cur_beats - 1);
            chk("err_sticky", err, (err_idx >= 0) && (cons > err_idx));
            if (data_last) n_last++;
            cons++;
        end
        if (hs_ar === 1'b1) begin
            ar_addr_q.push_back(m_axi_araddr);
            ar_len_q.push_back(m_axi_arlen);
            model_out++;
        end
        if (hs_r && rl) model_out--;
        prev_ar_stall = (m_axi_arvalid === 1'b1) && !m_axi_arready;
        prev_araddr   = m_axi_araddr;
        prev_arlen    = m_axi_arlen;
        acc = (hs_c === 1'b1);

        @(posedge ap_clk);
        #1;
        if (acc) begin
            cons = 0; axi_ser = 0; bib = 0; n_last = 0;
            cmd_no++;
            cur_beats = int'(cmd_beats);
            cmd_valid = 1'b0;
        end
        if (hs_ar === 1'b1) pend.push_back(int'(len_cap) + 1);
        if (hs_r) begin
            axi_ser++;
            if (rl) begin
                void'(pend.pop_front());
                bib = 0;
                r_bursts_allowed--;
            end else begin
                bib++;
            end
        end
        m_axi_rvalid = (pend.size() > 0) && (r_bursts_allowed > 0);
        if (m_axi_rvalid) begin
            m_axi_rdata = pat(cmd_no, axi_ser);
            m_axi_rlast = (bib == pend[0] - 1);
            m_axi_rresp = (axi_ser == err_idx) ? 2'b10 : 2'b00;
        end else begin
            m_axi_rdata = '0;
            m_axi_rlast = 1'b0;
            m_axi_rresp = 2'b00;
        end
        if (stall_cnt > 0 && m_axi_rvalid) begin
            data_ready = 1'b0;
            stall_cnt--;
        end else begin
            data_ready = 1'b1;
        end
        m_axi_arready = ar_slow ? (cyc % 3 == 2) : 1'b1;
        cyc++;
    endtask

    task automatic start_cmd(input logic [63:0] a, input int b);
        int k;
        ar_addr_q.delete();
        ar_len_q.delete();
        cmd_addr  = a;
        cmd_beats = 32'(b);
        cmd_valid = 1'b1;
        k = 0;
        acc = 0;
        while (!acc && k < 50) begin
            step();
            k++;
        end
        if (!acc) begin
            chk("cmd_accept_timeout", 0, 1);
            cmd_valid = 1'b0;
        end
    endtask

    task automatic do_cmd(input logic [63:0] a, input int b, input int budget);
        int  k;
        bit  done;
        start_cmd(a, b);
        k = 0;
        done = 0;
        while (!done && k < budget) begin
            if (!busy && cons == b) done = 1;
            else begin
                step();
                k++;
            end
        end
        if (!done) chk("cmd_done_timeout", 0, 1);
    endtask

    task automatic do_reset();
        areset = 1'b1;
        cmd_valid = 1'b0;
        prev_ar_stall = 1'b0;
        r_bursts_allowed = 0;
        step();
        pend.delete();
        model_out = 0;
        bib = 0;
    endtask

    vec_t vecs[8];

    initial begin
        areset = 1'b1;   cmd_valid = 1'b0;  cmd_addr = '0;  cmd_beats = '0;
        m_axi_arready = 1'b1; m_axi_rdata = '0; m_axi_rresp = 2'b00;
        m_axi_rlast = 1'b0; m_axi_rid = '0; m_axi_rvalid = 1'b0; data_ready = 1'b1;
        r_bursts_allowed = 1000000; stall_cnt = 0; err_idx = -1; cmd_no = 0;
        bib = 0; axi_ser = 0; cons = 0; n_last = 0; cur_beats = 0; model_out = 0;
        cyc = 0; ar_slow = 0; acc = 0; prev_ar_stall = 0; prev_araddr = '0; prev_arlen = '0;

        vecs[0] = mk(64'h0, 130, 3, 64'h0, 8'd63, 64'h1000, 8'd63, 64'h2000, 8'd1);
        vecs[1] = mk(64'h0FC0, 3, 2, 64'h0FC0, 8'd0, 64'h1000, 8'd1, 64'h0, 8'd0);
        vecs[2] = mk(64'h0F80, 5, 2, 64'h0F80, 8'd1, 64'h1000, 8'd2, 64'h0, 8'd0);
        vecs[3] = mk(64'h1234_5678_0000_0A3F, 1, 1, 64'h1234_5678_0000_0A00, 8'd0, 64'h0, 8'd0, 64'h0, 8'd0);
        vecs[4] = mk(64'hFFFF_FFFF_FFFF_FFC0, 2, 2, 64'hFFFF_FFFF_FFFF_FFC0, 8'd0, 64'h0, 8'd0, 64'h0, 8'd0);
        vecs[5] = mk(64'h40, 64, 2, 64'h40, 8'd62, 64'h1000, 8'd0, 64'h0, 8'd0);
        vecs[6] = mk(64'h3000, 100, 2, 64'h3000, 8'd63, 64'h4000, 8'd35, 64'h0, 8'd0);
        vecs[7] = mk(64'h7000, 0, 0, 64'h0, 8'd0, 64'h0, 8'd0, 64'h0, 8'd0);

        // reset state
        step();
        step();
        chk("rst_arvalid", m_axi_arvalid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_data_last", data_last, 0);
        chk("fix_arsize", m_axi_arsize, 3'd6);
        chk("fix_arburst", m_axi_arburst, 2'b01);
        chk("fix_arcache", m_axi_arcache, 4'b0011);
        chk("fix_zero", {m_axi_arprot, m_axi_arqos, m_axi_arregion, m_axi_arlock, m_axi_arid}, 0);
        areset = 1'b0;
        step();
        chk("idle_cmd_ready", cmd_ready, 1);

        // table-driven commands, arready throttled to exercise AR hold
        ar_slow = 1;
        for (int v = 0; v < 8; v++) begin
            do_cmd(vecs[v].addr, vecs[v].beats, 2000);
            chk("ar_count", ar_addr_q.size(), vecs[v].n_ar);
            for (int j = 0; j < vecs[v].n_ar && j < 3; j++) begin
                if (j < ar_addr_q.size()) begin
                    chk("ar_addr", ar_addr_q[j], vecs[v].ar_addr[j]);
                    chk("ar_len", ar_len_q[j], vecs[v].ar_len[j]);
                end
            end
            chk("beats_out", cons, vecs[v].beats);
            chk("last_count", n_last, vecs[v].beats > 0);
            chk("err_clean", err, 0);
        end
        ar_slow = 0;

        // downstream stall of 10 cycles while rvalid is high
        stall_cnt = 10;
        do_cmd(64'h5000, 20, 500);
        chk("stall_beats", cons, 20);
        chk("stall_last_count", n_last, 1);
        chk("stall_drained", stall_cnt, 0);

        // error response on beat 5 of 8, then cleared by next accept
        err_idx = 4;
        do_cmd(64'h8000, 8, 500);
        chk("err_at_end", err, 1);
        err_idx = -1;
        start_cmd(64'h9000, 0);
        chk("err_cleared", err, 0);
        chk("zero_cmd_ready_next", cmd_ready, 1);
        chk("zero_busy", busy, 0);
        repeat (5) step();
        chk("zero_no_ar", ar_addr_q.size(), 0);
        chk("zero_no_data", cons, 0);

        // outstanding cap: no R returned
        r_bursts_allowed = 0;
        start_cmd(64'h0, 1024);
        repeat (40) step();
        chk("cap_ar_count", ar_addr_q.size(), 8);
        chk("cap_arvalid_low", m_axi_arvalid, 0);
        r_bursts_allowed = 1;
        repeat (150) step();
        chk("cap_one_more_ar", ar_addr_q.size(), 9);
        chk("cap_arvalid_low2", m_axi_arvalid, 0);
        chk("cap_beats", cons, 64);
        chk("cap_busy", busy, 1);

        // reset mid-ISSUE, then prove the outstanding count was cleared
        do_reset();
        chk("midrst_arvalid", m_axi_arvalid, 0);
        chk("midrst_busy", busy, 0);
        areset = 1'b0;
        step();
        start_cmd(64'h0, 1024);
        repeat (40) step();
        chk("midrst_ar_count", ar_addr_q.size(), 8);
        do_reset();
        areset = 1'b0;
        r_bursts_allowed = 1000000;
        step();

        // normal command after recovery
        do_cmd(64'h2_0000, 70, 1000);
        chk("post_rst_beats", cons, 70);
        chk("post_rst_ar_count", ar_addr_q.size(), 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
